rr_arbiter8: RTL

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_if.sv | 20 ++
 rtl/rr_arbiter8.sv | 106 ++++++++++
 2 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the 8-way round-robin arbiter.
interface rr_arbiter8_if;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output enable, req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_id, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with a bounded hold time per grant.
// Every release forces one idle cycle before the next grant is issued.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);
  localparam int unsigned NREQ = 8;
  localparam int unsigned IDW  = 3;
  localparam int unsigned HW   = 8;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            expired;
  logic            rel;

  // First set request at or above ptr, wrapping modulo 8.
  always_comb begin
    pick  = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr_q + IDW'(i);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign expired = (hold_q == HOLD_LAST);
  assign rel     = bus.done || !bus.req[id_q] || expired;

  // Next state; the hold counter never passes HOLD_LAST because reaching it releases.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && found) begin
          state_d = BUSY;
          id_d    = pick;
          grant_d = NREQ'(1) << pick;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (rel) begin
          state_d   = IDLE;
          grant_d   = '0;
          valid_d   = 1'b0;
          ptr_d     = id_q + IDW'(1);
          timeout_d = expired && !bus.done;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = id_q;
  assign bus.grant_valid = valid_q;
  assign bus.timeout     = timeout_q;
endmodule
